// File: rtl/tdes_pkg.sv
// Register map, default window base and STATUS bit layout shared by the
// AHB-Lite 3DES register interface and its result FIFO.
package tdes_pkg;

    typedef enum logic [3:0] {
        TDES_OFF_CTRL   = 4'd0,
        TDES_OFF_KEY1   = 4'd1,
        TDES_OFF_KEY2   = 4'd2,
        TDES_OFF_KEY3   = 4'd3,
        TDES_OFF_DIN    = 4'd4,
        TDES_OFF_DOUT   = 4'd5,
        TDES_OFF_STATUS = 4'd6
    } tdes_off_e;

    localparam logic [31:0] TDES_BASE_ADDR = 32'hAAAAAAA0;

    // STATUS = {out_count, in_pending, key_err, out_underflow, out_overflow, in_overflow}
    localparam int TDES_ST_IN_OVF   = 0;
    localparam int TDES_ST_OUT_OVF  = 1;
    localparam int TDES_ST_OUT_UNF  = 2;
    localparam int TDES_ST_KEY_ERR  = 3;
    localparam int TDES_ST_IN_PEND  = 4;
    localparam int TDES_ST_OUT_CNT  = 5;

endpackage

// File: rtl/tdes_result_fifo.sv
// Synchronous result FIFO between the 3DES core and the bus. A push while full
// is only taken when a pop frees the head slot in the same cycle.
module tdes_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ahb_tdes_reg_if.sv
// AHB-Lite slave register front end for the 3DES core: mode/key registers,
// one-entry input block, result FIFO and sticky STATUS. Macro TDES_ERR_RESP_EN
// enables a one-cycle HRESP error on faulting data phases.
module ahb_tdes_reg_if
    import tdes_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TDES_BASE_ADDR,
    parameter int          OUT_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HADDR,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HRESP,
    output logic        core_encrypt,
    output logic [63:0] core_key1,
    output logic [63:0] core_key2,
    output logic [63:0] core_key3,
    output logic [63:0] core_data_in,
    output logic        core_in_valid,
    input  logic        core_in_ready,
    input  logic [63:0] core_data_out,
    input  logic        core_out_valid
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;

    logic [3:0]    addr_q;
    logic          write_q;
    logic          act_q;
    logic          hit_q;
    logic          encrypt_q;
    logic [63:0]   key1_q, key2_q, key3_q;
    logic [63:0]   in_buf;
    logic          in_pending;
    logic          in_ovf, out_ovf, out_unf, key_err;
    logic          sel_ctrl, sel_key1, sel_key2, sel_key3;
    logic          sel_din, sel_dout, sel_status, sel_unmapped;
    logic          in_accept, din_wr, din_drop, key_wr, key_block;
    logic          dout_rd, dout_unf, status_wr, push_drop;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [63:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic [63:0]   status_word;
    logic          unused_inputs;

    assign unused_inputs = ^{HSIZE, HTRANS[0]};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            act_q   <= 1'b0;
            write_q <= 1'b0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            act_q <= HSEL & HREADY & HTRANS[1];
            if (HSEL & HREADY & HTRANS[1]) begin
                addr_q  <= HADDR[3:0];
                write_q <= HWRITE;
                hit_q   <= (HADDR[31:4] == BASE_ADDR[31:4]);
            end
        end
    end

    // Anything outside the window or past STATUS is treated as unmapped.
    always_comb begin
        sel_ctrl     = 1'b0;
        sel_key1     = 1'b0;
        sel_key2     = 1'b0;
        sel_key3     = 1'b0;
        sel_din      = 1'b0;
        sel_dout     = 1'b0;
        sel_status   = 1'b0;
        sel_unmapped = 1'b0;
        if (act_q) begin
            if (!hit_q) begin
                sel_unmapped = 1'b1;
            end else begin
                case (addr_q)
                    TDES_OFF_CTRL:   sel_ctrl   = 1'b1;
                    TDES_OFF_KEY1:   sel_key1   = 1'b1;
                    TDES_OFF_KEY2:   sel_key2   = 1'b1;
                    TDES_OFF_KEY3:   sel_key3   = 1'b1;
                    TDES_OFF_DIN:    sel_din    = 1'b1;
                    TDES_OFF_DOUT:   sel_dout   = 1'b1;
                    TDES_OFF_STATUS: sel_status = 1'b1;
                    default:         sel_unmapped = 1'b1;
                endcase
            end
        end
    end

    assign in_accept = in_pending & core_in_ready;
    assign din_wr    = sel_din & write_q;
    assign din_drop  = din_wr & in_pending & ~core_in_ready;
    assign key_wr    = (sel_ctrl | sel_key1 | sel_key2 | sel_key3) & write_q;
    assign key_block = key_wr & in_pending;
    assign dout_rd   = sel_dout & ~write_q;
    assign fifo_pop  = dout_rd & ~fifo_empty;
    assign dout_unf  = dout_rd & fifo_empty;
    assign status_wr = sel_status & write_q;
    assign push_drop = core_out_valid & fifo_full & ~fifo_pop;

    // Sticky flags: a STATUS write clears them, but an event in the same cycle wins.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            encrypt_q  <= 1'b0;
            key1_q     <= '0;
            key2_q     <= '0;
            key3_q     <= '0;
            in_buf     <= '0;
            in_pending <= 1'b0;
            in_ovf     <= 1'b0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            if (write_q && !in_pending) begin
                if (sel_ctrl) encrypt_q <= HWDATA[0];
                if (sel_key1) key1_q    <= HWDATA;
                if (sel_key2) key2_q    <= HWDATA;
                if (sel_key3) key3_q    <= HWDATA;
            end
            if (din_wr && (!in_pending || core_in_ready)) begin
                in_buf     <= HWDATA;
                in_pending <= 1'b1;
            end else if (in_accept) begin
                in_pending <= 1'b0;
            end
            if (status_wr) begin
                in_ovf  <= 1'b0;
                out_ovf <= 1'b0;
                out_unf <= 1'b0;
                key_err <= 1'b0;
            end
            if (din_drop)  in_ovf  <= 1'b1;
            if (push_drop) out_ovf <= 1'b1;
            if (dout_unf)  out_unf <= 1'b1;
            if (key_block) key_err <= 1'b1;
        end
    end

    tdes_result_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (64)
    ) u_result_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (core_out_valid),
        .pop   (fifo_pop),
        .din   (core_data_out),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word                          = '0;
        status_word[TDES_ST_IN_OVF]          = in_ovf;
        status_word[TDES_ST_OUT_OVF]         = out_ovf;
        status_word[TDES_ST_OUT_UNF]         = out_unf;
        status_word[TDES_ST_KEY_ERR]         = key_err;
        status_word[TDES_ST_IN_PEND]         = in_pending;
        status_word[TDES_ST_OUT_CNT +: CW]   = fifo_count;
    end

    always_comb begin
        HRDATA = '0;
        if (!write_q) begin
            if (sel_ctrl)   HRDATA = {63'b0, encrypt_q};
            if (sel_key1)   HRDATA = key1_q;
            if (sel_key2)   HRDATA = key2_q;
            if (sel_key3)   HRDATA = key3_q;
            if (sel_dout)   HRDATA = fifo_empty ? 64'd0 : fifo_head;
            if (sel_status) HRDATA = status_word;
        end
    end

`ifdef TDES_ERR_RESP_EN
    assign HRESP = din_drop | dout_unf | key_block | sel_unmapped;
`else
    logic unused_unmapped;
    assign unused_unmapped = sel_unmapped;
    assign HRESP = 1'b0;
`endif

    assign core_encrypt  = encrypt_q;
    assign core_key1     = key1_q;
    assign core_key2     = key2_q;
    assign core_key3     = key3_q;
    assign core_data_in  = in_buf;
    assign core_in_valid = in_pending;

endmodule
